// File: rtl/rand_delay_timer_pkg.sv
// Shared types and constants for the one-shot delay timer.
package delay_timer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COUNTING = 2'd1,
    TIME_OUT = 2'd2,
    WAIT_LOW = 2'd3
  } dt_state_t;

  localparam logic [6:0] DEFAULT_TAPS7 = 7'b1000100;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RAND  = 1'b1;

endpackage

// File: rtl/rand_delay_timer_if.sv
// Control/status bundle between a timer client (master) and the delay timer (slave).
interface rand_delay_timer_if #(
  parameter int WIDTH = 7
);
  logic             trigger;
  logic             abort;
  logic             mode;
  logic [WIDTH-1:0] k_in;
  logic             time_out;
  logic             busy;
  logic [WIDTH-1:0] k_used;

  modport master (
    output trigger, abort, mode, k_in,
    input  time_out, busy, k_used
  );

  modport slave (
    input  trigger, abort, mode, k_in,
    output time_out, busy, k_used
  );
endinterface

// File: rtl/rand_delay_timer_lfsr.sv
// Free-running Fibonacci LFSR used as the random delay source; seeds to 1 so all-zero is unreachable.
module lfsr_gen
  import delay_timer_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS7)
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= WIDTH'(1);
    end else begin
      r_lfsr <= {r_lfsr[WIDTH-2:0], ^(r_lfsr & TAPS)};
    end
  end

  assign q = r_lfsr;

endmodule

// File: rtl/rand_delay_timer.sv
// One-shot programmable delay timer with abort and a one-cycle completion pulse.
// Build option RAND_DELAY_EN adds an LFSR delay source selected by mode.
//
// state    | meaning
// IDLE     | waiting for trigger; latches delay on start
// COUNTING | busy, counting down to zero (abort cancels)
// TIME_OUT | one-cycle completion pulse
// WAIT_LOW | pulse done, trigger still high; wait for release
module rand_delay_timer
  import delay_timer_pkg::*;
#(
  parameter int               WIDTH = 7,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(DEFAULT_TAPS7)
) (
  input  logic              clk,
  input  logic              rst,
  rand_delay_timer_if.slave bus
);

  dt_state_t        r_state;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] r_k_used;
  logic             r_time_out;
  logic             r_busy;

  logic [WIDTH-1:0] w_src;
  logic [WIDTH-1:0] w_delay;

`ifdef RAND_DELAY_EN
  logic [WIDTH-1:0] w_lfsr;

  lfsr_gen #(
    .WIDTH (WIDTH),
    .TAPS  (TAPS)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (w_lfsr)
  );

  assign w_src = (bus.mode == MODE_RAND) ? w_lfsr : bus.k_in;
`else
  logic w_unused_cfg;

  assign w_unused_cfg = bus.mode ^ (^TAPS);
  assign w_src        = bus.k_in;
`endif

  // A zero delay would need a negative count; treat it as the shortest legal delay.
  assign w_delay = (w_src == '0) ? WIDTH'(1) : w_src;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_k_used   <= '0;
      r_time_out <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_time_out <= 1'b0;
      r_busy     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.trigger) begin
            r_state  <= COUNTING;
            r_k_used <= w_delay;
            r_count  <= w_delay - WIDTH'(1);
            r_busy   <= 1'b1;
          end
        end
        COUNTING: begin
          if (bus.abort) begin
            r_state <= IDLE;
          end else if (r_count == '0) begin
            r_state    <= TIME_OUT;
            r_time_out <= 1'b1;
          end else begin
            r_count <= r_count - WIDTH'(1);
            r_busy  <= 1'b1;
          end
        end
        TIME_OUT: begin
          r_state <= bus.trigger ? WAIT_LOW : IDLE;
        end
        WAIT_LOW: begin
          if (!bus.trigger) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.time_out = r_time_out;
  assign bus.busy     = r_busy;
  assign bus.k_used   = r_k_used;

endmodule

// File: tb/tb_rand_delay_timer.sv
// Self-checking bench for rand_delay_timer: directed vector table, corner sequences, random vs model.
module tb_rand_delay_timer;

  localparam int         W     = 7;
  localparam logic [6:0] TAPS7 = 7'b1000100;

  logic clk = 1'b0;
  logic rst;

  rand_delay_timer_if #(.WIDTH(W)) bus ();

  rand_delay_timer #(.WIDTH(W), .TAPS(TAPS7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remaining busy cycles, pending pulse, waiting-for-release flag.
  int         m_rem;
  bit         m_pulse;
  bit         m_hold;
  int         m_kused;
  logic [6:0] m_lfsr;

  task automatic model_edge(input bit r, input bit t, input bit a, input bit md, input int k);
    logic [6:0] nxt;
    int         d;
    nxt = {m_lfsr[5:0], ^(m_lfsr & TAPS7)};
    if (r) begin
      m_rem = 0; m_pulse = 0; m_hold = 0; m_kused = 0; m_lfsr = 7'd1;
      return;
    end
    if (m_rem > 0) begin
      if (a) m_rem = 0;
      else begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_pulse = 1;
      end
    end else if (m_pulse) begin
      m_pulse = 0;
      m_hold  = t;
    end else if (m_hold) begin
      if (!t) m_hold = 0;
    end else if (t) begin
`ifdef RAND_DELAY_EN
      d = md ? int'(m_lfsr) : k;
`else
      d = k;
`endif
      if (d == 0) d = 1;
      m_kused = d;
      m_rem   = d;
    end
    m_lfsr = nxt;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit t, input bit a, input bit md, input int k);
    rst         = r;
    bus.trigger = t;
    bus.abort   = a;
    bus.mode    = md;
    bus.k_in    = W'(k);
    model_edge(r, t, a, md, k);
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit rst;
    bit trig;
    bit abort;
    int k;
    bit e_to;
    bit e_busy;
    int e_kused;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit t, input bit a, input int k,
                     input bit eto, input bit ebusy, input int ek);
    vec_t v;
    v.rst = r; v.trig = t; v.abort = a; v.k = k;
    v.e_to = eto; v.e_busy = ebusy; v.e_kused = ek;
    vecs.push_back(v);
  endtask

  int pulses;
  int busy_cyc;

  initial begin
    rst = 1'b1; bus.trigger = 1'b0; bus.abort = 1'b0; bus.mode = 1'b0; bus.k_in = '0;
    m_rem = 0; m_pulse = 0; m_hold = 0; m_kused = 0; m_lfsr = 7'd1;

    // Rows: rst, trig, abort, k_in | time_out, busy, k_used after the edge.
    add(1, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 5, 0, 1, 5);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 5, 0, 1, 5);
    add(0, 0, 0, 5, 1, 0, 5);
    add(0, 0, 0, 5, 0, 0, 5);
    add(0, 1, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 1);
    add(0, 0, 0, 0, 0, 0, 1);
    add(0, 1, 0, 4, 0, 1, 4);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 4, 0, 1, 4);
    add(0, 0, 1, 4, 0, 0, 4);
    add(0, 0, 0, 4, 0, 0, 4);
    add(0, 0, 1, 9, 0, 0, 4);
    add(0, 1, 0, 2, 0, 1, 2);
    add(0, 0, 0, 2, 0, 1, 2);
    add(0, 0, 0, 2, 1, 0, 2);
    add(0, 0, 0, 2, 0, 0, 2);
    add(0, 1, 0, 1, 0, 1, 1);
    add(0, 1, 0, 1, 1, 0, 1);
    add(0, 1, 0, 1, 0, 0, 1);
    add(0, 1, 0, 9, 0, 0, 1);
    add(0, 0, 0, 9, 0, 0, 1);
    add(0, 1, 0, 3, 0, 1, 3);
    add(0, 0, 0, 3, 0, 1, 3);
    add(0, 0, 0, 3, 0, 1, 3);
    add(0, 0, 0, 3, 1, 0, 3);
    add(0, 0, 0, 3, 0, 0, 3);

    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].trig, vecs[i].abort, 1'b0, vecs[i].k);
      chk($sformatf("vec%0d_to", i),    int'(bus.time_out), int'(vecs[i].e_to));
      chk($sformatf("vec%0d_busy", i),  int'(bus.busy),     int'(vecs[i].e_busy));
      chk($sformatf("vec%0d_kused", i), int'(bus.k_used),   vecs[i].e_kused);
    end

    // Held trigger: exactly one pulse, then release re-arms.
    pulses = 0; busy_cyc = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 1, 0, 0, 3);
      pulses   += int'(bus.time_out);
      busy_cyc += int'(bus.busy);
    end
    chk("held_pulses", pulses, 1);
    chk("held_busy_cycles", busy_cyc, 3);
    step(0, 0, 0, 0, 3);
    chk("held_release_busy", int'(bus.busy), 0);
    step(0, 1, 0, 0, 2);
    chk("rearm_busy", int'(bus.busy), 1);
    chk("rearm_kused", int'(bus.k_used), 2);
    step(0, 0, 0, 0, 2);
    step(0, 0, 0, 0, 2);
    chk("rearm_to", int'(bus.time_out), 1);
    step(0, 0, 0, 0, 2);

    // Reset in the middle of a long count drops everything.
    step(0, 1, 0, 0, 100);
    for (int i = 0; i < 39; i++) step(0, 0, 0, 0, 100);
    chk("midcount_busy_before", int'(bus.busy), 1);
    step(1, 0, 0, 0, 100);
    chk("rst_to", int'(bus.time_out), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_kused", int'(bus.k_used), 0);
    pulses = 0; busy_cyc = 0;
    for (int i = 0; i < 110; i++) begin
      step(0, 0, 0, 0, 100);
      pulses   += int'(bus.time_out);
      busy_cyc += int'(bus.busy);
    end
    chk("rst_no_pulse", pulses, 0);
    chk("rst_no_busy", busy_cyc, 0);

`ifdef RAND_DELAY_EN
    // LFSR snapshots after reset: 1, 2, 4, 9, 18, 36 ...
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 50);
    chk("rand_kused_first", int'(bus.k_used), 2);
    chk("rand_busy_first", int'(bus.busy), 1);
    step(0, 0, 0, 1, 50);
    chk("rand_busy_second", int'(bus.busy), 1);
    step(0, 0, 0, 1, 50);
    chk("rand_to_latency", int'(bus.time_out), 1);
    step(0, 0, 0, 1, 50);
    step(0, 1, 0, 1, 50);
    chk("rand_kused_second", int'(bus.k_used), 36);
`endif

    // Randomized traffic against the model.
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++) begin
      bit r, t, a, md;
      int k;
      r  = ($urandom_range(0, 299) == 0);
      t  = ($urandom_range(0, 9) < 3);
      a  = ($urandom_range(0, 29) == 0);
      md = $urandom_range(0, 1) == 1;
      k  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(0, 10));
      step(r, t, a, md, k);
      chk("rnd_to",    int'(bus.time_out), int'(m_pulse));
      chk("rnd_busy",  int'(bus.busy),     (m_rem > 0) ? 1 : 0);
      chk("rnd_kused", int'(bus.k_used),   m_kused);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
